// File: rtl/controller_op_stack_if.sv
// Operator-stack bus between the infix-parsing controller (master) and the
// operator stack (slave): push/pop/clear commands in, top-of-stack status out.
`ifndef CO_N
`define CO_N 8
`endif

interface controller_op_stack_if #(
   parameter int WIDTH = `CO_N,
   parameter int CW    = 5
);
   logic             op_push;
   logic             op_pop;
   logic             op_clear;
   logic [WIDTH-1:0] op_din;
   logic [WIDTH-1:0] op_data;
   logic             op_empty;
   logic             op_full;
   logic [CW-1:0]    op_count;
   logic             op_err;

   modport master (
      output op_push, op_pop, op_clear, op_din,
      input  op_data, op_empty, op_full, op_count, op_err
   );

   modport slave (
      input  op_push, op_pop, op_clear, op_din,
      output op_data, op_empty, op_full, op_count, op_err
   );
endinterface

// File: rtl/controller_op_stack.sv
// Operator stack feeding the precedence stage; the top entry is kept in its
// own register so op_data is a pure flop output with no read-mux behind it.
`ifndef CO_N
`define CO_N 8
`endif

module controller_op_stack #(
   parameter int WIDTH = `CO_N,
   parameter int DEPTH = 16,
   parameter int CW    = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   controller_op_stack_if.slave  io_op
);
   localparam int            AW      = CW - 1;
   localparam logic [CW-1:0] C_ZERO  = CW'(1'b0);
   localparam logic [CW-1:0] C_ONE   = CW'(1'b1);
   localparam logic [CW-1:0] C_TWO   = CW'(2'd2);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_top;
   logic             r_err;

   logic [CW-1:0]    w_count_nxt;
   logic [WIDTH-1:0] w_top_nxt;
   logic             w_err_nxt;
   logic             w_wr_en;
   logic [AW-1:0]    w_wr_addr;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_below_idx;
   logic             w_empty;
   logic             w_full;

   assign w_empty     = (r_count == C_ZERO);
   assign w_full      = (r_count == C_DEPTH);
   assign w_top_idx   = AW'(r_count - C_ONE);
   assign w_below_idx = AW'(r_count - C_TWO);

   // Next-state decode of the command priority for count, top, error and write port
   always_comb begin
      w_count_nxt = r_count;
      w_top_nxt   = r_top;
      w_err_nxt   = r_err;
      w_wr_en     = 1'b0;
      w_wr_addr   = AW'(1'b0);
      if (io_op.op_clear) begin
         w_count_nxt = C_ZERO;
         w_top_nxt   = WIDTH'(1'b0);
         w_err_nxt   = 1'b0;
      end else begin
         case ({io_op.op_push, io_op.op_pop})
            2'b10: begin
               if (!w_full) begin
                  w_wr_en     = 1'b1;
                  w_wr_addr   = AW'(r_count);
                  w_count_nxt = r_count + C_ONE;
                  w_top_nxt   = io_op.op_din;
               end else begin
                  w_err_nxt   = 1'b1;
               end
            end
            2'b01: begin
               if (!w_empty) begin
                  w_count_nxt = r_count - C_ONE;
                  // Entry below the current top becomes visible; nothing below a single entry
                  if (r_count == C_ONE) begin
                     w_top_nxt = WIDTH'(1'b0);
                  end else begin
                     w_top_nxt = r_mem[w_below_idx];
                  end
               end else begin
                  w_err_nxt   = 1'b1;
               end
            end
            2'b11: begin
               w_wr_en   = 1'b1;
               w_top_nxt = io_op.op_din;
               if (!w_empty) begin
                  w_wr_addr   = w_top_idx;
               end else begin
                  w_wr_addr   = AW'(1'b0);
                  w_count_nxt = C_ONE;
                  w_err_nxt   = 1'b1;
               end
            end
            default: begin
               w_count_nxt = r_count;
            end
         endcase
      end
   end

   // Control state: count, registered top and sticky error with synchronous reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= C_ZERO;
         r_top   <= WIDTH'(1'b0);
         r_err   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_top   <= w_top_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Storage array; contents after reset are don't-care so it carries no reset
   always_ff @(posedge i_clk) begin
      if (i_rst_n && w_wr_en) begin
         r_mem[w_wr_addr] <= io_op.op_din;
      end
   end

   assign io_op.op_data  = r_top;
   assign io_op.op_count = r_count;
   assign io_op.op_err   = r_err;
   assign io_op.op_empty = w_empty;
   assign io_op.op_full  = w_full;
endmodule

// File: tb/tb_controller_op_stack.sv
// Self-checking bench for controller_op_stack: directed plan plus random
// commands checked against a queue-based stack model.
module tb_controller_op_stack;
   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   int   model_q[$];
   bit   model_err;

   controller_op_stack_if #(.WIDTH(WIDTH), .CW(CW)) op_bus ();

   controller_op_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_op   (op_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit push, input bit pop, input bit clr, input int din);
      if (!rst || clr) begin
         model_q.delete();
         model_err = 1'b0;
      end else if (push && !pop) begin
         if (model_q.size() < DEPTH) model_q.push_back(din);
         else model_err = 1'b1;
      end else if (!push && pop) begin
         if (model_q.size() > 0) void'(model_q.pop_back());
         else model_err = 1'b1;
      end else if (push && pop) begin
         if (model_q.size() > 0) model_q[model_q.size()-1] = din;
         else begin
            model_q.push_back(din);
            model_err = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      int exp_data;
      sz       = model_q.size();
      exp_data = (sz > 0) ? model_q[sz-1] : 0;
      check_eq({tag, ".data"},  32'(op_bus.op_data),  32'(exp_data));
      check_eq({tag, ".count"}, 32'(op_bus.op_count), 32'(sz));
      check_eq({tag, ".empty"}, 32'(op_bus.op_empty), 32'(sz == 0));
      check_eq({tag, ".full"},  32'(op_bus.op_full),  32'(sz == DEPTH));
      check_eq({tag, ".err"},   32'(op_bus.op_err),   32'(model_err));
   endtask

   // Drive one command at the falling edge, clock it in, then check just after the rising edge
   task automatic step(input string tag, input bit rst, input bit push, input bit pop,
                       input bit clr, input int din);
      rst_n           = rst;
      op_bus.op_push  = push;
      op_bus.op_pop   = pop;
      op_bus.op_clear = clr;
      op_bus.op_din   = WIDTH'(din);
      @(posedge clk);
      model_step(rst, push, pop, clr, din);
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   initial begin
      int r;
      pass_cnt  = 0;
      total_cnt = 0;
      model_err = 1'b0;
      rst_n     = 1'b0;
      op_bus.op_push  = 1'b0;
      op_bus.op_pop   = 1'b0;
      op_bus.op_clear = 1'b0;
      op_bus.op_din   = '0;
      @(negedge clk);

      step("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      step("rst1", 1'b0, 1'b1, 1'b0, 1'b0, 9);
      step("idle", 1'b1, 1'b0, 1'b0, 1'b0, 0);

      step("push3", 1'b1, 1'b1, 1'b0, 1'b0, 3);
      check_eq("push3.lit", 32'(op_bus.op_data), 32'd3);
      step("push5", 1'b1, 1'b1, 1'b0, 1'b0, 5);
      step("push9", 1'b1, 1'b1, 1'b0, 1'b0, 9);
      check_eq("push9.lit", 32'(op_bus.op_data), 32'd9);
      step("pop1", 1'b1, 1'b0, 1'b1, 1'b0, 0);
      check_eq("pop1.lit", 32'(op_bus.op_data), 32'd5);
      step("pop2", 1'b1, 1'b0, 1'b1, 1'b0, 0);
      step("pop3", 1'b1, 1'b0, 1'b1, 1'b0, 0);
      check_eq("pop3.lit", 32'(op_bus.op_data), 32'd0);

      for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b1, 1'b0, 1'b0, i);
      check_eq("fill.full.lit", 32'(op_bus.op_full), 32'd1);
      step("ovf", 1'b1, 1'b1, 1'b0, 1'b0, 7);
      check_eq("ovf.data.lit", 32'(op_bus.op_data), 32'd16);
      check_eq("ovf.err.lit", 32'(op_bus.op_err), 32'd1);
      step("fullrep", 1'b1, 1'b1, 1'b1, 1'b0, 33);
      step("clr", 1'b1, 1'b0, 1'b0, 1'b1, 0);

      step("unf", 1'b1, 1'b0, 1'b1, 1'b0, 0);
      check_eq("unf.err.lit", 32'(op_bus.op_err), 32'd1);
      step("push4", 1'b1, 1'b1, 1'b0, 1'b0, 4);
      check_eq("push4.err.lit", 32'(op_bus.op_err), 32'd1);
      step("clr2", 1'b1, 1'b1, 1'b1, 1'b1, 0);

      step("p2", 1'b1, 1'b1, 1'b0, 1'b0, 2);
      step("p6", 1'b1, 1'b1, 1'b0, 1'b0, 6);
      step("rep8", 1'b1, 1'b1, 1'b1, 1'b0, 8);
      check_eq("rep8.lit", 32'(op_bus.op_data), 32'd8);
      step("pop_rep", 1'b1, 1'b0, 1'b1, 1'b0, 0);
      step("pop_rep2", 1'b1, 1'b0, 1'b1, 1'b0, 0);
      step("pp_empty", 1'b1, 1'b1, 1'b1, 1'b0, 3);
      check_eq("pp_empty.cnt.lit", 32'(op_bus.op_count), 32'd1);

      for (int i = 0; i < 4; i++) step("to5", 1'b1, 1'b1, 1'b0, 1'b0, 20 + i);
      step("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 11);
      check_eq("midrst.empty.lit", 32'(op_bus.op_empty), 32'd1);
      step("post1", 1'b1, 1'b1, 1'b0, 1'b0, 1);

      for (int i = 0; i < 3000; i++) begin
         bit rs;
         bit pu;
         bit po;
         bit cl;
         r  = int'($urandom_range(0, 99));
         rs = ($urandom_range(0, 199) != 0);
         cl = ($urandom_range(0, 59) == 0);
         if (model_q.size() > 12) begin
            pu = (r < 30); po = (r >= 20);
         end else begin
            pu = (r < 60); po = (r >= 45);
         end
         step("rand", rs, pu, po, cl, int'($urandom_range(0, 255)));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/controller_op_stack.md
Name: controller_op_stack

Overview:
- Operator stack that feeds the precedence stage.
- Holds pending operator codes (`CO_N-wide) pushed by the main controller while it parses infix input.
- Presents the top entry as op_data with op_empty, the operator-memory inputs the precedence logic compares against the incoming operator.
- Single clock; all state changes on the rising edge; synchronous active-low reset.

Parameters:
WIDTH, `CO_N, operator code width in bits.
DEPTH, 16, number of stack entries; must be a power of two, at least 2.
CW, 5, count width; must equal log2(DEPTH)+1.

Ports:
Clock  input  1  system clock, rising-edge active.
Reset  input  1  synchronous, active-low reset.
op_push  input  1  push op_din this cycle.
op_pop  input  1  pop top entry this cycle.
op_clear  input  1  empty the stack and clear op_err.
op_din  input  WIDTH  operator code to push.
op_data  output  WIDTH  current top entry; 0 when empty.
op_empty  output  1  count == 0.
op_full  output  1  count == DEPTH.
op_count  output  CW  number of valid entries.
op_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset low at a rising edge:
  - count=0, op_err=0, op_data=0, op_empty=1, op_full=0.
  - Storage contents are don't-care.
  - Reset overrides every command asserted in the same cycle, including mid-sequence.
- Outputs are functions of registered state only: no combinational path from op_push/op_pop/op_clear/op_din to any output.
- Latency: a command sampled at edge N is visible on outputs after edge N; op_data shows the new top in the cycle following the edge.
- Command priority per edge, with Reset high:
  1. op_clear=1: count=0, op_err=0; push/pop ignored.
  2. push=1, pop=0, not full: mem[count]<=op_din, count+1.
  3. push=1, pop=0, full: no change, op_err<=1 (overflow).
  4. push=0, pop=1, not empty: count-1.
  5. push=0, pop=1, empty: no change, op_err<=1 (underflow).
  6. push=1, pop=1, not empty: replace the top, mem[count-1]<=op_din; count unchanged; legal even when full.
  7. push=1, pop=1, empty: treat as push, so mem[0]<=op_din, count=1; op_err<=1 (underflow).
  8. No command: hold all state.
- op_err stays set until op_clear or Reset; further legal operations do not clear it.
- op_data = mem[count-1] when count>0, else 0.
- op_empty and op_full are decoded from the registered count, never stored separately.
- count saturates within 0..DEPTH; wrap-around is impossible by construction. A push at count=DEPTH never writes mem.
- Implementation: register array plus count register, or an equivalent with an explicitly registered top. Either way op_data must match the rule above every cycle.

Test Plan:
- Reset then idle: hold Reset low 2 cycles -> op_empty=1, op_count=0, op_data=0, op_err=0; the same holds with op_push=1 during reset.
- Push 3,5,9 on consecutive cycles, then pop x3 -> op_data 3,5,9 after each push edge; then 5,3,0 after the pops; op_empty=1 at the end, op_err=0.
- Fill to DEPTH=16 with codes 1..16 -> op_full=1, op_data=16. One more push of 7 -> op_data still 16, op_count=16, op_err=1. op_clear -> op_count=0, op_err=0.
- Pop on empty -> op_err=1, op_count=0. Then push 4 -> op_data=4, op_err stays 1.
- Simultaneous push+pop:
  - With stack [2,6], push 8 + pop -> op_count=2, op_data=8.
  - On an empty stack, push 3 + pop -> op_count=1, op_data=3, op_err=1.
- Reset mid-operation: at count=5, assert Reset low with op_push=1 -> next cycle op_count=0, op_empty=1. After release, push 1 -> op_count=1, op_data=1.
